// File: rtl/idct_blk_sched_pkg.sv
// Shared constants, FSM encoding and bus element helpers for the IDCT block scheduler.
package idct_blk_sched_pkg;

    localparam int unsigned ML = 16;      // coefficient/sample width
    localparam int unsigned N  = 8;       // block dimension (fixed)
    localparam int unsigned CW = 3;       // row/column counter width
    localparam int unsigned BW = N * ML;  // packed row/column bus width

    typedef enum logic {
        ST_ROW = 1'b0,
        ST_COL = 1'b1
    } state_t;

    // Extract element k from a packed N*ML bus.
    function automatic logic [ML-1:0] get_elem(input logic [BW-1:0] bus, input logic [CW-1:0] k);
        return bus[ML*32'(k) +: ML];
    endfunction

    // Return the bus with element k replaced by val.
    function automatic logic [BW-1:0] set_elem(input logic [BW-1:0] bus, input logic [CW-1:0] k,
                                               input logic [ML-1:0] val);
        logic [BW-1:0] res;
        res = bus;
        res[ML*32'(k) +: ML] = val;
        return res;
    endfunction

endpackage

// File: rtl/idct_blk_sched_tbuf.sv
// 8x8 transpose buffer: whole-row write port, combinational whole-column read port.
// Storage is intentionally not reset; contents are don't-care until written.
module idct_tbuf
    import idct_blk_sched_pkg::*;
(
    input  logic          clock,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_row,
    input  logic [BW-1:0] wr_data,
    input  logic [CW-1:0] rd_col,
    output logic [BW-1:0] rd_data
);

    logic [ML-1:0] mem [N][N];

    // Row write: element k of wr_data lands in mem[wr_row][k].
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int k = 0; k < int'(N); k++) begin
                mem[wr_row][k] <= get_elem(wr_data, CW'(k));
            end
        end
    end

    // Column read: element r of rd_data is mem[r][rd_col].
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < int'(N); r++) begin
            rd_data = set_elem(rd_data, CW'(r), mem[r][rd_col]);
        end
    end

endmodule

// File: rtl/idct_blk_sched.sv
// IDCT block scheduler: streams 8 rows through the external row unit into a
// transpose buffer, then 8 columns through the external column unit.
// Optional build macro IDCT_BLK_SCHED_BLKCNT_EN adds a 32-bit blk_count output
// counting completed output blocks.
module idct_blk_sched
    import idct_blk_sched_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_row,
    output logic [BW-1:0] row_op,
    input  logic [BW-1:0] row_res,
    output logic [BW-1:0] col_op,
    input  logic [BW-1:0] col_res,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_col,
    output logic [2:0]    out_idx,
    output logic          out_last,
    output logic          busy
`ifdef IDCT_BLK_SCHED_BLKCNT_EN
    ,
    output logic [31:0]   blk_count
`endif
);

    state_t        state, state_nx;
    logic [CW-1:0] row_cnt, row_cnt_nx;
    logic [CW-1:0] col_cnt, col_cnt_nx;
    logic          wr_en;

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_ROW;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state   <= state_nx;
            row_cnt <= row_cnt_nx;
            col_cnt <= col_cnt_nx;
        end
    end

    // Next-state, counter advance and handshake decode.
    always_comb begin
        state_nx   = state;
        row_cnt_nx = row_cnt;
        col_cnt_nx = col_cnt;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            ST_ROW: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en      = 1'b1;
                    row_cnt_nx = row_cnt + CW'(1);
                    if (row_cnt == CW'(N - 1)) state_nx = ST_COL;
                end
            end
            ST_COL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    col_cnt_nx = col_cnt + CW'(1);
                    if (col_cnt == CW'(N - 1)) state_nx = ST_ROW;
                end
            end
            default: state_nx = ST_ROW;
        endcase
    end

    // Datapath pass-throughs and status derived from the registered state.
    always_comb begin
        row_op   = in_row;
        out_col  = col_res;
        out_idx  = col_cnt;
        out_last = (state == ST_COL) && (col_cnt == CW'(N - 1));
        busy     = (row_cnt != '0) || (state == ST_COL);
    end

    idct_tbuf u_tbuf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_row  (row_cnt),
        .wr_data (row_res),
        .rd_col  (col_cnt),
        .rd_data (col_op)
    );

`ifdef IDCT_BLK_SCHED_BLKCNT_EN
    // Completed-block counter, advanced on the last output column handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blk_count <= '0;
        end else if (out_valid && out_ready && out_last) begin
            blk_count <= blk_count + 32'd1;
        end
    end
`endif

endmodule
